// File: rtl/unidade_controle_jogo_timeout_if.sv
// Control/status bundle between the sequence-game control unit and its datapath.
// master = control unit side, slave = datapath / top-level side.
interface unidade_controle_jogo_timeout_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim_contagem;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, fim_contagem,
    output zeraC, contaC, zeraR, registraR, acertou, errou, pronto,
           db_timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, fim_contagem,
    input  zeraC, contaC, zeraR, registraR, acertou, errou, pronto,
           db_timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_timeout.sv
// Moore control unit for the exp4 sequence game with per-play inactivity timeout.
// Define UC_TIMEOUT_EN to build the timeout counter and the fim_timeout exit.
module unidade_controle_jogo_timeout #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 16
) (
  input logic                           clock,
  input logic                           reset,
  unidade_controle_jogo_timeout_if.master bus
);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROXIMA       = 4'h6,
    FIM_ACERTO    = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERRO      = 4'hE
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   timeout_s;

  logic zera_c_s, conta_c_s, zera_r_s, registra_r_s;
  logic acertou_s, errou_s, pronto_s, db_timeout_s;
  logic zera_c_r, conta_c_r, zera_r_r, registra_r_r;
  logic acertou_r, errou_r, pronto_r, db_timeout_r;

`ifdef UC_TIMEOUT_EN
  localparam logic [TW-1:0] TERM_C = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] MAX_C  = {TW{1'b1}};

  logic [TW-1:0] count_r;

  // Inactivity counter: runs only while waiting for a play, saturating, zero elsewhere.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= {TW{1'b0}};
    end else if (state_r == ESPERA_JOGADA) begin
      if (count_r != MAX_C) begin
        count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end else begin
      count_r <= {TW{1'b0}};
    end
  end

  assign timeout_s = (count_r == TERM_C);
`else
  logic unused_cfg_s;

  assign unused_cfg_s = (TIMEOUT_CYCLES > TW);
  assign timeout_s    = 1'b0;
`endif

  // Next-state logic; a play pulse takes priority over the terminal count.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      INICIAL:       next_state_s = bus.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    next_state_s = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (bus.jogada) begin
          next_state_s = REGISTRA;
        end else if (timeout_s) begin
          next_state_s = FIM_TIMEOUT;
        end else begin
          next_state_s = ESPERA_JOGADA;
        end
      end
      REGISTRA:      next_state_s = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igual) begin
          next_state_s = FIM_ERRO;
        end else if (bus.fim_contagem) begin
          next_state_s = FIM_ACERTO;
        end else begin
          next_state_s = PROXIMA;
        end
      end
      PROXIMA:       next_state_s = ESPERA_JOGADA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT:   next_state_s = bus.iniciar ? PREPARACAO : state_r;
      default:       next_state_s = INICIAL;
    endcase
  end

  // Output decode of the upcoming state so the registered outputs track the state register.
  always_comb begin
    zera_c_s     = 1'b0;
    conta_c_s    = 1'b0;
    zera_r_s     = 1'b0;
    registra_r_s = 1'b0;
    acertou_s    = 1'b0;
    errou_s      = 1'b0;
    pronto_s     = 1'b0;
    db_timeout_s = 1'b0;
    case (next_state_s)
      INICIAL:     zera_r_s = 1'b1;
      PREPARACAO: begin
        zera_c_s = 1'b1;
        zera_r_s = 1'b1;
      end
      REGISTRA:    registra_r_s = 1'b1;
      PROXIMA:     conta_c_s = 1'b1;
      FIM_ACERTO: begin
        acertou_s = 1'b1;
        pronto_s  = 1'b1;
      end
      FIM_ERRO: begin
        errou_s  = 1'b1;
        pronto_s = 1'b1;
      end
      FIM_TIMEOUT: begin
        errou_s      = 1'b1;
        pronto_s     = 1'b1;
        db_timeout_s = 1'b1;
      end
      default: begin
        zera_c_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= INICIAL;
      zera_c_r     <= 1'b0;
      conta_c_r    <= 1'b0;
      zera_r_r     <= 1'b1;
      registra_r_r <= 1'b0;
      acertou_r    <= 1'b0;
      errou_r      <= 1'b0;
      pronto_r     <= 1'b0;
      db_timeout_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      zera_c_r     <= zera_c_s;
      conta_c_r    <= conta_c_s;
      zera_r_r     <= zera_r_s;
      registra_r_r <= registra_r_s;
      acertou_r    <= acertou_s;
      errou_r      <= errou_s;
      pronto_r     <= pronto_s;
      db_timeout_r <= db_timeout_s;
    end
  end

  assign bus.zeraC      = zera_c_r;
  assign bus.contaC     = conta_c_r;
  assign bus.zeraR      = zera_r_r;
  assign bus.registraR  = registra_r_r;
  assign bus.acertou    = acertou_r;
  assign bus.errou      = errou_r;
  assign bus.pronto     = pronto_r;
  assign bus.db_timeout = db_timeout_r;
  assign bus.db_estado  = state_r;

endmodule
